// File: rtl/pwm_seq_loader.sv
`default_nettype none
// ============================================================================
// Module   : pwm_seq_loader
// Purpose  : Frame-stepped (A,B) count sequencer feeding the PWM generator.
//            Optional macro PWM_SEQ_LIVE_WRITE_EN allows table writes while busy.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_seq_loader #(
    parameter int WIDTH = 7,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic             clkCore,
    input  logic             reset,
    input  logic             clkZ,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_a,
    input  logic [WIDTH-1:0] wr_b,
    input  logic [AW-1:0]    seq_last,
    input  logic             loop,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] A_val,
    output logic [WIDTH-1:0] B_val,
    output logic             en,
    output logic             busy,
    output logic [AW-1:0]    idx,
    output logic             done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_z_meta;
    logic               r_z_sync;
    logic               r_z_prev;
    logic               w_frame_tick;
    logic               w_step;
    logic               w_at_last;
    logic               w_load;
    logic               w_finish;
    logic               w_wr_fire;
    logic               w_fwd;
    logic [AW-1:0]      w_nxt_idx;
    logic [2*WIDTH-1:0] r_table [DEPTH];
    logic [WIDTH-1:0]   r_nxt_a;
    logic [WIDTH-1:0]   r_nxt_b;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [AW-1:0]      r_idx;
    logic [AW-1:0]      r_last;
    logic               r_loop;
    logic               r_done;

    // clkZ is asynchronous: two-flop synchronizer plus rising-edge detect
    always_ff @(posedge clkCore) begin
        if (!reset) begin
            r_z_meta <= 1'b0;
            r_z_sync <= 1'b0;
            r_z_prev <= 1'b0;
        end else begin
            r_z_meta <= clkZ;
            r_z_sync <= r_z_meta;
            r_z_prev <= r_z_sync;
        end
    end

    assign w_frame_tick = r_z_sync & ~r_z_prev;
    // any start/stop pulse in the tick cycle suppresses the table step
    assign w_step       = w_frame_tick & ~start & ~stop;
    assign w_at_last    = (r_idx == r_last);
    assign w_finish     = (r_state == S_RUN) & w_step & w_at_last & ~r_loop;
    assign w_load       = w_step & ((r_state == S_ARM) |
                                    ((r_state == S_RUN) & ~(w_at_last & ~r_loop)));
    assign w_nxt_idx    = ((r_state == S_RUN) && !w_at_last) ? r_idx + 1'b1 : '0;
    assign w_wr_fire    = wr_valid & wr_ready;

`ifdef PWM_SEQ_LIVE_WRITE_EN
    assign w_fwd = w_wr_fire & (wr_addr == w_nxt_idx);
`else
    assign w_fwd = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clkCore) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start && !stop) w_state_nxt = S_ARM;
            S_ARM: begin
                if (stop)        w_state_nxt = S_IDLE;
                else if (w_step) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (stop)          w_state_nxt = S_IDLE;
                else if (w_finish) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (r_state != S_IDLE);
        en   = (r_state == S_RUN);
`ifdef PWM_SEQ_LIVE_WRITE_EN
        wr_ready = 1'b1;
`else
        wr_ready = (r_state == S_IDLE);
`endif
        A_val = r_a;
        B_val = r_b;
        idx   = r_idx;
        done  = r_done;
    end

    always_ff @(posedge clkCore) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else if (w_wr_fire) begin
            r_table[wr_addr] <= {wr_a, wr_b};
        end
    end

    // Prefetch refreshes every cycle, so it follows idx one cycle after each update
    always_ff @(posedge clkCore) begin
        if (!reset) begin
            r_nxt_a <= '0;
            r_nxt_b <= '0;
        end else if (w_fwd) begin
            r_nxt_a <= wr_a;
            r_nxt_b <= wr_b;
        end else begin
            {r_nxt_a, r_nxt_b} <= r_table[w_nxt_idx];
        end
    end

    always_ff @(posedge clkCore) begin
        if (!reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_idx  <= '0;
            r_last <= '0;
            r_loop <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_finish;
            if ((r_state == S_IDLE) && start && !stop) begin
                r_last <= seq_last;
                r_loop <= loop;
            end
            if (w_load) begin
                r_a   <= r_nxt_a;
                r_b   <= r_nxt_b;
                r_idx <= w_nxt_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_seq_loader.sv
`default_nettype none
// Testbench for pwm_seq_loader: directed vector table, hand-written corner
// sequences and randomized operations against a frame-level reference model.
module tb_pwm_seq_loader;
    localparam int WIDTH = 7;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef PWM_SEQ_LIVE_WRITE_EN
    localparam bit LIVE = 1'b1;
`else
    localparam bit LIVE = 1'b0;
`endif

    logic             clkCore = 1'b0;
    logic             reset   = 1'b0;
    logic             clkZ    = 1'b0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [AW-1:0]    wr_addr = '0;
    logic [WIDTH-1:0] wr_a = '0;
    logic [WIDTH-1:0] wr_b = '0;
    logic [AW-1:0]    seq_last = '0;
    logic             loop  = 1'b0;
    logic             start = 1'b0;
    logic             stop  = 1'b0;
    logic [WIDTH-1:0] A_val;
    logic [WIDTH-1:0] B_val;
    logic             en;
    logic             busy;
    logic [AW-1:0]    idx;
    logic             done;

    pwm_seq_loader #(.WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH)) dut (
        .clkCore(clkCore), .reset(reset), .clkZ(clkZ),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_a(wr_a), .wr_b(wr_b), .seq_last(seq_last), .loop(loop),
        .start(start), .stop(stop), .A_val(A_val), .B_val(B_val),
        .en(en), .busy(busy), .idx(idx), .done(done)
    );

    always #5 clkCore = ~clkCore;

    int checks = 0;
    int errors = 0;

    // Reference model: the table, whether armed/running, and the play position
    int m_tab_a [DEPTH];
    int m_tab_b [DEPTH];
    bit m_armed, m_running, m_loop;
    int m_pos, m_last, m_a, m_b;

    localparam int OP_WR = 0, OP_START = 1, OP_FRAME = 2;
    typedef struct {
        int op; int p0; int p1; int p2;
        int ea; int eb; int een; int eidx; int edone;
    } vec_t;
    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clkCore);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_tab_a[i] = 0;
            m_tab_b[i] = 0;
        end
        m_armed = 0; m_running = 0; m_loop = 0;
        m_pos = 0; m_last = 0; m_a = 0; m_b = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".A_val"}, 32'(A_val), 32'(m_a));
        chk({tag, ".B_val"}, 32'(B_val), 32'(m_b));
        chk({tag, ".en"},    32'(en),    32'(m_running));
        chk({tag, ".busy"},  32'(busy),  32'(m_armed | m_running));
        chk({tag, ".idx"},   32'(idx),   32'(m_pos));
        chk({tag, ".done"},  32'(done),  32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        model_clear();
    endtask

    task automatic op_write(input int adr, input int a, input int b);
        bit exp_ready;
        exp_ready = LIVE || !(m_armed || m_running);
        wr_valid = 1'b1;
        wr_addr  = AW'(adr);
        wr_a     = WIDTH'(a);
        wr_b     = WIDTH'(b);
        #1;
        chk("wr_ready", 32'(wr_ready), 32'(exp_ready));
        cyc();
        wr_valid = 1'b0;
        if (exp_ready) begin
            m_tab_a[adr] = a;
            m_tab_b[adr] = b;
        end
    endtask

    task automatic op_start(input int last, input bit lp);
        seq_last = AW'(last);
        loop     = lp;
        start    = 1'b1;
        cyc();
        start = 1'b0;
        if (!(m_armed || m_running)) begin
            m_armed = 1;
            m_last  = last;
            m_loop  = lp;
        end
    endtask

    task automatic op_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        m_armed   = 0;
        m_running = 0;
    endtask

    task automatic op_frame(output int dcount);
        logic [31:0] old_dut, old_exp, new_exp;
        int lat, exp_done;
        lat = -1;
        dcount = 0;
        exp_done = 0;
        old_dut = {A_val, B_val, en, busy, idx};
        old_exp = {7'(m_a), 7'(m_b), 1'(m_running), 1'(m_armed | m_running), 4'(m_pos)};
        #2 clkZ = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            if (lat < 0 && {A_val, B_val, en, busy, idx} != old_dut[19:0]) lat = k;
            dcount += int'(done);
        end
        clkZ = 1'b0;
        repeat (3) cyc();
        if (m_armed) begin
            m_armed = 0; m_running = 1; m_pos = 0;
        end else if (m_running) begin
            if (m_pos != m_last) m_pos++;
            else if (m_loop) m_pos = 0;
            else begin
                m_running = 0;
                exp_done = 1;
            end
        end
        if (m_running) begin
            m_a = m_tab_a[m_pos];
            m_b = m_tab_b[m_pos];
        end
        new_exp = {7'(m_a), 7'(m_b), 1'(m_running), 1'(m_armed | m_running), 4'(m_pos)};
        if (new_exp != old_exp)
            chk("frame_latency_2_to_3", 32'(lat >= 2 && lat <= 3), 32'd1);
        chk("frame_done_pulses", 32'(dcount), 32'(exp_done));
        check_all("frame");
    endtask

    function automatic vec_t mk(input int op, input int p0, input int p1, input int p2,
                                input int ea, input int eb, input int een,
                                input int eidx, input int edone);
        vec_t v;
        v.op = op; v.p0 = p0; v.p1 = p1; v.p2 = p2;
        v.ea = ea; v.eb = eb; v.een = een; v.eidx = eidx; v.edone = edone;
        return v;
    endfunction

    initial begin
        int dc;
        int r;
        // one-shot over entries 0..2
        vecs.push_back(mk(OP_WR, 0, 10, 20,  0,  0, 0, 0, 0));
        vecs.push_back(mk(OP_WR, 1, 30, 40,  0,  0, 0, 0, 0));
        vecs.push_back(mk(OP_WR, 2, 50, 60,  0,  0, 0, 0, 0));
        vecs.push_back(mk(OP_START, 2, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(OP_FRAME, 0, 0, 0, 10, 20, 1, 0, 0));
        vecs.push_back(mk(OP_FRAME, 0, 0, 0, 30, 40, 1, 1, 0));
        vecs.push_back(mk(OP_FRAME, 0, 0, 0, 50, 60, 1, 2, 0));
        vecs.push_back(mk(OP_FRAME, 0, 0, 0, 50, 60, 0, 2, 1));
        // looping over the same table
        vecs.push_back(mk(OP_START, 2, 1, 0, 50, 60, 0, 2, 0));
        vecs.push_back(mk(OP_FRAME, 0, 0, 0, 10, 20, 1, 0, 0));
        vecs.push_back(mk(OP_FRAME, 0, 0, 0, 30, 40, 1, 1, 0));
        vecs.push_back(mk(OP_FRAME, 0, 0, 0, 50, 60, 1, 2, 0));
        vecs.push_back(mk(OP_FRAME, 0, 0, 0, 10, 20, 1, 0, 0));
        vecs.push_back(mk(OP_FRAME, 0, 0, 0, 30, 40, 1, 1, 0));
        vecs.push_back(mk(OP_FRAME, 0, 0, 0, 50, 60, 1, 2, 0));
        vecs.push_back(mk(OP_FRAME, 0, 0, 0, 10, 20, 1, 0, 0));

        model_clear();
        reset = 1'b0;
        repeat (3) cyc();
        reset = 1'b1;
        check_all("reset");
        chk("reset.wr_ready", 32'(wr_ready), 32'd1);

        foreach (vecs[i]) begin
            dc = 0;
            case (vecs[i].op)
                OP_WR:    op_write(vecs[i].p0, vecs[i].p1, vecs[i].p2);
                OP_START: op_start(vecs[i].p0, vecs[i].p1[0]);
                default:  op_frame(dc);
            endcase
            chk($sformatf("vec%0d.A_val", i), 32'(A_val), 32'(vecs[i].ea));
            chk($sformatf("vec%0d.B_val", i), 32'(B_val), 32'(vecs[i].eb));
            chk($sformatf("vec%0d.en", i),    32'(en),    32'(vecs[i].een));
            chk($sformatf("vec%0d.idx", i),   32'(idx),   32'(vecs[i].eidx));
            chk($sformatf("vec%0d.done", i),  32'(dc),    32'(vecs[i].edone));
        end

        // stop mid-RUN at idx=1, then further frames change nothing
        op_frame(dc);
        chk("pre_stop.idx", 32'(idx), 32'd1);
        op_stop();
        check_all("stop");
        chk("stop.en", 32'(en), 32'd0);
        op_frame(dc);
        op_frame(dc);
        chk("after_stop.A_val", 32'(A_val), 32'd30);
        chk("after_stop.idx", 32'(idx), 32'd1);

        // start and stop together in IDLE: stays IDLE
        seq_last = 4'd1; loop = 1'b0;
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk("start_stop.busy", 32'(busy), 32'd0);
        check_all("start_stop");

        // start landing in the frame_tick cycle: ARM, no step yet
        #2 clkZ = 1'b1;
        cyc(); cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        m_armed = 1; m_last = 1; m_loop = 0;
        chk("start_on_tick.busy", 32'(busy), 32'd1);
        clkZ = 1'b0;
        repeat (4) cyc();
        check_all("start_on_tick");
        chk("start_on_tick.en", 32'(en), 32'd0);
        op_frame(dc);
        chk("armed_frame.A_val", 32'(A_val), 32'd10);

        // write while running
        op_write(5, 77, 66);
`ifdef PWM_SEQ_LIVE_WRITE_EN
        op_stop();
        op_start(1, 1'b0);
        #2 clkZ = 1'b1;
        repeat (3) cyc();
        chk("live_pre.A_val", 32'(A_val), 32'd10);
        wr_valid = 1'b1; wr_addr = 4'd1; wr_a = 7'd99; wr_b = 7'd98;
        cyc();
        wr_valid = 1'b0;
        chk("live_no_direct.A_val", 32'(A_val), 32'd10);
        clkZ = 1'b0;
        repeat (3) cyc();
        m_armed = 0; m_running = 1; m_pos = 0; m_a = 10; m_b = 20;
        m_tab_a[1] = 99; m_tab_b[1] = 98;
        check_all("live_write");
        op_frame(dc);
        chk("live_fwd.A_val", 32'(A_val), 32'd99);
        chk("live_fwd.B_val", 32'(B_val), 32'd98);
`else
        chk("run_write.wr_ready", 32'(wr_ready), 32'd0);
        op_frame(dc);
        chk("stalled_write.A_val", 32'(A_val), 32'd30);
`endif
        op_frame(dc);
        chk("oneshot2.done", 32'(dc), 32'd1);

        // reset in RUN at idx=2, then table proves cleared
        op_start(2, 1'b1);
        repeat (3) op_frame(dc);
        chk("pre_reset.idx", 32'(idx), 32'd2);
        do_reset();
        check_all("mid_reset");
        op_start(0, 1'b0);
        op_frame(dc);
        chk("cleared.A_val", 32'(A_val), 32'd0);
        chk("cleared.en", 32'(en), 32'd1);
        op_frame(dc);
        chk("cleared.done", 32'(dc), 32'd1);

        // randomized operations against the model
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 28)      op_write(int'($urandom_range(0, DEPTH - 1)),
                                      int'($urandom_range(0, 127)),
                                      int'($urandom_range(0, 127)));
            else if (r < 42) op_start(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            else if (r < 49) op_stop();
            else if (r < 50) do_reset();
            else             op_frame(dc);
            check_all("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
